// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF     = 5;
    localparam int unsigned MC_LATENCY_DEF = 4;
    localparam int unsigned STAT_W         = 32;

    // RUN: normal issue; MC_WAIT: a multi-cycle op is draining its remaining EX cycles.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_e;

    // Hold/bubble controls for every pipeline_register stage.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } hz_ctrl_t;

    // Counter width that holds MC_LATENCY-2 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 2) ? $clog2(lat - 1) : 1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives hazard sources, consumes controls).
// slave : hazard controller.
interface pipeline_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) ();

    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_mem_read_i;
    logic              ex_branch_taken_i;
    logic              ex_mc_start_i;
    logic              mem_ready_i;

    logic              pc_stall_o;
    logic              if_id_stall_o;
    logic              id_ex_stall_o;
    logic              ex_mem_stall_o;
    logic              if_id_flush_o;
    logic              id_ex_flush_o;
    logic              ex_mem_flush_o;
    logic              mem_wb_flush_o;
    logic              mc_busy_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, ex_mc_start_i, mem_ready_i,
        input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
               mc_busy_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, ex_mc_start_i, mem_ready_i,
        output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
               if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
               mc_busy_o
    );

endinterface

// File: rtl/hazard_perf_counters.sv
// Hazard statistics: cycles with PC stalled and cycles with an IF/ID flush.
// Present only when HAZARD_STATS_EN is defined; counters wrap at 2^32.
`ifdef HAZARD_STATS_EN
module hazard_perf_counters
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_stall_i,
    input  logic              if_id_flush_i,
    output logic [STAT_W-1:0] stall_cycles_o,
    output logic [STAT_W-1:0] flush_events_o
);

    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Next counter values; natural modulo-2^32 wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q + STAT_W'(pc_stall_i);
        flush_cnt_d = flush_cnt_q + STAT_W'(if_id_flush_i);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the 5-stage RV32 pipeline.
// Priority: MEM wait > multi-cycle EX op > taken-branch redirect > load-use.
// Controls are combinational from registered FSM state and current inputs.
// Optional macro HAZARD_STATS_EN adds stall/flush statistics ports.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned MC_LATENCY = MC_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]      stall_cycles_o,
    output logic [STAT_W-1:0]      flush_events_o
`endif
);

    localparam int unsigned CNT_W = cnt_width(MC_LATENCY);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hz_ctrl_t         ctrl_c;
    logic             load_use_c;
    logic             mc_hold_c;

    // State and remaining-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus prioritised stall/flush decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_c     = '0;
        load_use_c = hz.ex_mem_read_i && (hz.ex_rd_i != REG_AW'(0)) &&
                     ((hz.id_use_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                      (hz.id_use_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));
        mc_hold_c  = ((state_q == RUN) && hz.ex_mc_start_i) ||
                     ((state_q == MC_WAIT) && (cnt_q != '0));

        if (!hz.mem_ready_i) begin
            // Whole pipe frozen; the MC counter does not advance.
            ctrl_c.pc_stall     = 1'b1;
            ctrl_c.if_id_stall  = 1'b1;
            ctrl_c.id_ex_stall  = 1'b1;
            ctrl_c.ex_mem_stall = 1'b1;
            ctrl_c.mem_wb_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.ex_mc_start_i) begin
                        state_d = MC_WAIT;
                        cnt_d   = CNT_W'(MC_LATENCY - 2);
                    end
                end
                MC_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase

            if (mc_hold_c) begin
                ctrl_c.pc_stall     = 1'b1;
                ctrl_c.if_id_stall  = 1'b1;
                ctrl_c.id_ex_stall  = 1'b1;
                ctrl_c.ex_mem_flush = 1'b1;
            end else if (hz.ex_branch_taken_i) begin
                ctrl_c.if_id_flush  = 1'b1;
                ctrl_c.id_ex_flush  = 1'b1;
            end else if (load_use_c) begin
                ctrl_c.pc_stall     = 1'b1;
                ctrl_c.if_id_stall  = 1'b1;
                ctrl_c.id_ex_flush  = 1'b1;
            end
        end

        // Controls are held inactive for as long as reset is asserted.
        if (!rst_n) begin
            ctrl_c = '0;
        end
    end

    assign hz.pc_stall_o     = ctrl_c.pc_stall;
    assign hz.if_id_stall_o  = ctrl_c.if_id_stall;
    assign hz.id_ex_stall_o  = ctrl_c.id_ex_stall;
    assign hz.ex_mem_stall_o = ctrl_c.ex_mem_stall;
    assign hz.if_id_flush_o  = ctrl_c.if_id_flush;
    assign hz.id_ex_flush_o  = ctrl_c.id_ex_flush;
    assign hz.ex_mem_flush_o = ctrl_c.ex_mem_flush;
    assign hz.mem_wb_flush_o = ctrl_c.mem_wb_flush;
    assign hz.mc_busy_o      = (state_q == MC_WAIT);

`ifdef HAZARD_STATS_EN
    hazard_perf_counters u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_stall_i     (ctrl_c.pc_stall),
        .if_id_flush_i  (ctrl_c.if_id_flush),
        .stall_cycles_o (stall_cycles_o),
        .flush_events_o (flush_events_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MC_LATENCY = 4).
// Each row drives one cycle of inputs and queues the expected controls;
// the queue is popped and compared at the following falling edge.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    // Expected control vectors: {pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_MEM  = 8'b1111_0001;
    localparam logic [7:0] C_MC   = 8'b1110_0010;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [7:0] C_LU   = 8'b1100_0100;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic       mc;
        logic       br;
        logic       mrd;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [7:0] ectrl;
        logic       ebusy;
    } stim_t;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.REG_AW(5)) hif ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    pipeline_hazard_ctrl #(.REG_AW(5), .MC_LATENCY(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hz             (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_events_o (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    stim_t       rows[$];
    logic [8:0]  sb[$];
    logic [8:0]  exp_v;
    logic [8:0]  obs_v;

    function automatic stim_t mk(input logic rst, input logic rdy, input logic mc,
                                 input logic br, input logic mrd, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [7:0] ectrl, input logic ebusy);
        stim_t s;
        s.rst = rst;  s.rdy = rdy;  s.mc = mc;   s.br = br;   s.mrd = mrd;
        s.rd  = rd;   s.rs1 = rs1;  s.u1 = u1;   s.rs2 = rs2; s.u2 = u2;
        s.ectrl = ectrl; s.ebusy = ebusy;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rst_n                 = s.rst;
        hif.mem_ready_i       = s.rdy;
        hif.ex_mc_start_i     = s.mc;
        hif.ex_branch_taken_i = s.br;
        hif.ex_mem_read_i     = s.mrd;
        hif.ex_rd_i           = s.rd;
        hif.id_rs1_i          = s.rs1;
        hif.id_use_rs1_i      = s.u1;
        hif.id_rs2_i          = s.rs2;
        hif.id_use_rs2_i      = s.u2;
    endtask

    function automatic logic [8:0] observed();
        return {hif.pc_stall_o, hif.if_id_stall_o, hif.id_ex_stall_o, hif.ex_mem_stall_o,
                hif.if_id_flush_o, hif.id_ex_flush_o, hif.ex_mem_flush_o, hif.mem_wb_flush_o,
                hif.mc_busy_o};
    endfunction

    task automatic test_reset();
        rows.delete();
        rows.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(0, 1, 1, 1, 1, 5, 5, 1, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL reset[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0)
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stall_cycles, flush_events);
        else n_pass++;
`endif
    endtask

    task automatic test_load_use();
        rows.delete();
        rows.push_back(mk(1, 1, 0, 0, 1, 5, 5, 1, 0, 0, C_LU,   0));
        rows.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 0, 0, 1, 9, 3, 1, 9, 1, C_LU,   0));
        rows.push_back(mk(1, 1, 0, 0, 1, 7, 7, 0, 2, 1, C_NONE, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 5, 5, 1, 5, 1, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL load_use[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_mc_op();
        rows.delete();
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   0));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL mc_op[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if (stall_cycles !== 32'd3)
            $display("FAIL mc_stall_cycles: got %0d want 3", stall_cycles);
        else n_pass++;
`endif
    endtask

    task automatic test_mem_wait();
        rows.delete();
        rows.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_MEM,  0));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   0));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_MEM,  1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MEM,  1));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL mem_wait[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        rows.delete();
        rows.push_back(mk(1, 1, 0, 1, 1, 5, 5, 1, 0, 0, C_BR,   0));
        rows.push_back(mk(1, 1, 1, 1, 1, 5, 5, 1, 0, 0, C_MC,   0));
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 0, 1, 1, 5, 5, 1, 0, 0, C_BR,   1));
        rows.push_back(mk(1, 0, 1, 1, 1, 5, 5, 1, 0, 0, C_MEM,  0));
        rows.push_back(mk(1, 1, 0, 0, 1, 5, 5, 1, 0, 0, C_LU,   0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL priority[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        rows.delete();
        for (int k = 0; k < 2; k++) begin
            rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   0));
            rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
            rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
            rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
        end
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL back_to_back[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mc();
        rows.delete();
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_MC,   0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_MC,   1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL reset_mid_mc[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        rows.delete();
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        rows.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, C_BR,   0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i]);
            sb.push_back({rows[i].ectrl, rows[i].ebusy});
            @(negedge clk);
            exp_v = sb.pop_front();
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL stats[%0d]: got %b want %b", i, obs_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (flush_events !== 32'd1 || stall_cycles !== 32'd0)
            $display("FAIL stats_counts: got flush=%0d stall=%0d want 1/0", flush_events, stall_cycles);
        else n_pass++;
    endtask
`endif

    initial begin
        drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0));
        test_reset();
        test_load_use();
        test_mc_op();
        test_mem_wait();
        test_priority();
        test_back_to_back();
        test_reset_mid_mc();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
